// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: frame parser states, error flags
// and the clocks-per-bit figure also used by the UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        S_HUNT    = 3'd0,
        S_LEN     = 3'd1,
        S_PAYLOAD = 3'd2,
        S_CHK     = 3'd3,
        S_OUT     = 3'd4
    } state_t;

    typedef struct packed {
        logic len;
        logic chk;
        logic timeout;
        logic overrun;
    } err_t;

    localparam logic [7:0] DEF_SOF_BYTE = 8'h55;

    function automatic int calc_cycle(input int clk_fre, input int baud_rate);
        return clk_fre * 1000000 / baud_rate;
    endfunction

endpackage

// File: rtl/frame_buf.sv
// Payload store: registered write port, combinational read port.
// Addresses at or beyond MAX_LEN are ignored on write and read back as zero.
module frame_buf #(
    parameter int MAX_LEN = 16,
    parameter int PW      = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [PW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [PW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);
    localparam int            AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [PW-1:0] DEPTH = PW'(MAX_LEN);

    logic [7:0] r_mem [MAX_LEN];

    always_ff @(posedge clk) begin
        if (i_we && (i_waddr < DEPTH)) r_mem[i_waddr[AW-1:0]] <= i_wdata;
    end

    assign o_rdata = (i_raddr < DEPTH) ? r_mem[i_raddr[AW-1:0]] : 8'h00;

endmodule

// File: rtl/uart_frame_parser.sv
// Parses SOF/LEN/PAYLOAD/CHK frames from the UART receiver, buffers the payload
// and streams it out with valid/ready once the checksum has matched.
module uart_frame_parser
    import uart_pkg::*;
#(
    parameter int         CLK_FRE       = 50,
    parameter int         BAUD_RATE     = 115200,
    parameter int         MAX_LEN       = 16,
    parameter logic [7:0] SOF_BYTE      = DEF_SOF_BYTE,
    parameter int         TIMEOUT_BYTES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_data_ready,
    output logic        o_rx_data_valid,
    output logic [7:0]  o_pkt_data,
    output logic        o_pkt_valid,
    output logic        o_pkt_last,
    input  logic        i_pkt_ready,
    output logic        o_err_len,
    output logic        o_err_chk,
    output logic        o_err_timeout,
    output logic        o_err_overrun,
    output logic [15:0] o_frame_cnt
);
    localparam int            PW        = $clog2(MAX_LEN + 1);
    localparam int            TO_LIMIT  = TIMEOUT_BYTES * 10 * calc_cycle(CLK_FRE, BAUD_RATE);
    localparam int            TW        = $clog2(TO_LIMIT + 1);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TW-1:0] TO_LAST   = TW'(TO_LIMIT - 1);
    localparam logic [TW-1:0] TO_ONE    = TW'(1);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);

    state_t        r_state, w_state_nxt;
    logic          r_ready_d, r_rx_valid;
    logic [PW-1:0] r_len, w_len_nxt;
    logic [PW-1:0] r_wr_ptr, w_wr_ptr_nxt;
    logic [PW-1:0] r_rd_ptr, w_rd_ptr_nxt;
    logic [7:0]    r_sum, w_sum_nxt;
    logic [TW-1:0] r_to_cnt, w_to_cnt_nxt;
    logic [15:0]   r_frame_cnt;
    err_t          r_err, w_err;
    logic [7:0]    w_rd_data;
    logic          w_stb, w_we, w_frame_ok, w_last, w_to_hit, w_in_frame;

    assign w_stb      = i_rx_data_ready & ~r_ready_d;
    assign w_last     = (r_rd_ptr == r_len - PTR_ONE);
    assign w_to_hit   = (r_to_cnt == TO_LAST);
    assign w_in_frame = (r_state == S_LEN) || (r_state == S_PAYLOAD) || (r_state == S_CHK);

    always_comb begin
        w_state_nxt  = r_state;
        w_len_nxt    = r_len;
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_sum_nxt    = r_sum;
        w_to_cnt_nxt = '0;
        w_we         = 1'b0;
        w_frame_ok   = 1'b0;
        w_err        = '0;
        case (r_state)
            S_HUNT: begin
                if (w_stb && (i_rx_data == SOF_BYTE)) w_state_nxt = S_LEN;
            end
            S_LEN: begin
                if (w_stb) begin
                    if ((i_rx_data == 8'd0) || (i_rx_data > MAX_LEN_B)) begin
                        w_err.len   = 1'b1;
                        w_state_nxt = S_HUNT;
                    end else begin
                        w_len_nxt    = i_rx_data[PW-1:0];
                        w_sum_nxt    = i_rx_data;
                        w_wr_ptr_nxt = '0;
                        w_state_nxt  = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (w_stb) begin
                    w_we         = 1'b1;
                    w_sum_nxt    = r_sum + i_rx_data;
                    w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
                    if (r_wr_ptr == r_len - PTR_ONE) w_state_nxt = S_CHK;
                end
            end
            S_CHK: begin
                if (w_stb) begin
                    if (i_rx_data == r_sum) begin
                        w_rd_ptr_nxt = '0;
                        w_frame_ok   = 1'b1;
                        w_state_nxt  = S_OUT;
                    end else begin
                        w_err.chk   = 1'b1;
                        w_state_nxt = S_HUNT;
                    end
                end
            end
            S_OUT: begin
                // Bytes arriving while draining are acked and dropped.
                if (w_stb) w_err.overrun = 1'b1;
                if (i_pkt_ready) begin
                    w_rd_ptr_nxt = r_rd_ptr + PTR_ONE;
                    if (w_last) w_state_nxt = S_HUNT;
                end
            end
            default: w_state_nxt = S_HUNT;
        endcase
        // A byte landing on the limit cycle wins over the timeout.
        if (w_in_frame && !w_stb) begin
            if (w_to_hit) begin
                w_err.timeout = 1'b1;
                w_state_nxt   = S_HUNT;
            end else begin
                w_to_cnt_nxt = r_to_cnt + TO_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_HUNT;
            r_ready_d   <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_len       <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_sum       <= '0;
            r_to_cnt    <= '0;
            r_frame_cnt <= '0;
            r_err       <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ready_d  <= i_rx_data_ready;
            r_rx_valid <= w_stb;
            r_len      <= w_len_nxt;
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_sum      <= w_sum_nxt;
            r_to_cnt   <= w_to_cnt_nxt;
            r_err      <= w_err;
            if (w_frame_ok) r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    frame_buf #(
        .MAX_LEN (MAX_LEN),
        .PW      (PW)
    ) u_frame_buf (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (i_rx_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_data)
    );

    assign o_rx_data_valid = r_rx_valid;
    assign o_pkt_valid     = (r_state == S_OUT);
    assign o_pkt_data      = o_pkt_valid ? w_rd_data : 8'h00;
    assign o_pkt_last      = o_pkt_valid & w_last;
    assign o_err_len       = r_err.len;
    assign o_err_chk       = r_err.chk;
    assign o_err_timeout   = r_err.timeout;
    assign o_err_overrun   = r_err.overrun;
    assign o_frame_cnt     = r_frame_cnt;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Bench for uart_frame_parser: a table of whole frames plus hand-written timeout,
// back-pressure, overrun and mid-frame reset sequences; payload checked via a scoreboard.
module tb_uart_frame_parser;
    localparam int CLK_FRE       = 1;
    localparam int BAUD_RATE     = 100000;
    localparam int MAX_LEN       = 16;
    localparam int TIMEOUT_BYTES = 4;
    localparam int TO_LIMIT      = TIMEOUT_BYTES * 10 * (CLK_FRE * 1000000 / BAUD_RATE);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready = 1'b0;
    logic        rx_data_valid;
    logic [7:0]  pkt_data;
    logic        pkt_valid, pkt_last;
    logic        pkt_ready = 1'b1;
    logic        err_len, err_chk, err_timeout, err_overrun;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    uart_frame_parser #(
        .CLK_FRE       (CLK_FRE),
        .BAUD_RATE     (BAUD_RATE),
        .MAX_LEN       (MAX_LEN),
        .SOF_BYTE      (8'h55),
        .TIMEOUT_BYTES (TIMEOUT_BYTES)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_rx_data       (rx_data),
        .i_rx_data_ready (rx_ready),
        .o_rx_data_valid (rx_data_valid),
        .o_pkt_data      (pkt_data),
        .o_pkt_valid     (pkt_valid),
        .o_pkt_last      (pkt_last),
        .i_pkt_ready     (pkt_ready),
        .o_err_len       (err_len),
        .o_err_chk       (err_chk),
        .o_err_timeout   (err_timeout),
        .o_err_overrun   (err_overrun),
        .o_frame_cnt     (frame_cnt)
    );

    typedef struct {
        logic [0:7][7:0] b;
        int              n;
        logic [0:3][7:0] p;
        int              np;
        int              e_len;
        int              e_chk;
    } vec_t;

    vec_t       vecs[7];
    int         checks = 0, errors = 0;
    int         n_rxv = 0, n_len = 0, n_chk = 0, n_to = 0, n_ovr = 0;
    int         exp_frames = 0;
    logic [8:0] sb[$];
    logic       stall_prev = 1'b0;
    logic [8:0] stall_val = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Observes one cycle of outputs; called between clock edges.
    task automatic sample();
        logic [8:0] e;
        int ne;
        ne = 32'(err_len) + 32'(err_chk) + 32'(err_timeout) + 32'(err_overrun);
        if (ne != 0) chk("one_err_per_cycle", ne, 1);
        n_rxv += 32'(rx_data_valid);
        n_len += 32'(err_len);
        n_chk += 32'(err_chk);
        n_to  += 32'(err_timeout);
        n_ovr += 32'(err_overrun);
        if (stall_prev && pkt_valid) chk("stall_hold", 32'({pkt_last, pkt_data}), 32'(stall_val));
        stall_prev = pkt_valid && !pkt_ready;
        stall_val  = {pkt_last, pkt_data};
        if (pkt_valid && pkt_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pkt: got %0h, expected no output", {pkt_last, pkt_data});
            end else begin
                e = sb.pop_front();
                chk("pkt_last_data", 32'({pkt_last, pkt_data}), 32'(e));
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        tick();
    endtask

    task automatic drain();
        int n = 0;
        while (pkt_valid && n < 200) begin
            tick();
            n++;
        end
        if (pkt_valid) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: pkt_valid still 1 after %0d cycles, required 0", n);
        end
        tick();
        tick();
    endtask

    task automatic push_payload(input logic [0:3][7:0] p, input int np);
        for (int i = 0; i < np; i++) sb.push_back({(i == np - 1), p[i]});
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_rxv"}, 32'(rx_data_valid), 0);
        chk({tag, "_pkt"}, 32'({pkt_valid, pkt_last, pkt_data}), 0);
        chk({tag, "_errs"}, 32'({err_len, err_chk, err_timeout, err_overrun}), 0);
        chk({tag, "_frame_cnt"}, 32'(frame_cnt), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b_rxv, b_len, b_chk, b_to, b_ovr, n;

        vecs[0] = '{b: {8'h55, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69, 8'h00, 8'h00}, n: 6,
                    p: {8'h11, 8'h22, 8'h33, 8'h00}, np: 3, e_len: 0, e_chk: 0};
        vecs[1] = '{b: {8'h55, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6A, 8'h00, 8'h00}, n: 6,
                    p: {8'h00, 8'h00, 8'h00, 8'h00}, np: 0, e_len: 0, e_chk: 1};
        vecs[2] = '{b: {8'h55, 8'h01, 8'hAB, 8'hAC, 8'h00, 8'h00, 8'h00, 8'h00}, n: 4,
                    p: {8'hAB, 8'h00, 8'h00, 8'h00}, np: 1, e_len: 0, e_chk: 0};
        vecs[3] = '{b: {8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, n: 2,
                    p: {8'h00, 8'h00, 8'h00, 8'h00}, np: 0, e_len: 1, e_chk: 0};
        vecs[4] = '{b: {8'h55, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, n: 2,
                    p: {8'h00, 8'h00, 8'h00, 8'h00}, np: 0, e_len: 1, e_chk: 0};
        vecs[5] = '{b: {8'hAA, 8'h00, 8'h55, 8'h02, 8'h55, 8'h55, 8'hAC, 8'h00}, n: 7,
                    p: {8'h55, 8'h55, 8'h00, 8'h00}, np: 2, e_len: 0, e_chk: 0};
        vecs[6] = '{b: {8'h55, 8'h02, 8'h01, 8'h02, 8'h05, 8'h00, 8'h00, 8'h00}, n: 5,
                    p: {8'h01, 8'h02, 8'h00, 8'h00}, np: 2, e_len: 0, e_chk: 0};

        // Reset state
        #12;
        check_idle_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        foreach (vecs[k]) begin
            b_rxv = n_rxv; b_len = n_len; b_chk = n_chk; b_to = n_to; b_ovr = n_ovr;
            push_payload(vecs[k].p, vecs[k].np);
            if (vecs[k].np > 0) exp_frames++;
            for (int i = 0; i < vecs[k].n; i++) send_byte(vecs[k].b[i]);
            drain();
            chk($sformatf("v%0d_rx_ack", k), n_rxv - b_rxv, vecs[k].n);
            chk($sformatf("v%0d_err_len", k), n_len - b_len, vecs[k].e_len);
            chk($sformatf("v%0d_err_chk", k), n_chk - b_chk, vecs[k].e_chk);
            chk($sformatf("v%0d_err_to", k), n_to - b_to, 0);
            chk($sformatf("v%0d_err_ovr", k), n_ovr - b_ovr, 0);
            chk($sformatf("v%0d_frame_cnt", k), 32'(frame_cnt), exp_frames);
            chk($sformatf("v%0d_sb_empty", k), sb.size(), 0);
        end

        // Timeout mid-payload, then recovery
        b_to = n_to;
        send_byte(8'h55); send_byte(8'h02); send_byte(8'h11);
        n = 0;
        while (n_to == b_to && n < TO_LIMIT + 50) begin
            tick();
            n++;
        end
        chk("timeout_fired", n_to - b_to, 1);
        chk("timeout_latency", n, TO_LIMIT);
        chk("timeout_no_out", sb.size(), 0);
        push_payload({8'h07, 8'h00, 8'h00, 8'h00}, 1);
        exp_frames++;
        send_byte(8'h55); send_byte(8'h01); send_byte(8'h07); send_byte(8'h08);
        drain();
        chk("to_recover_frame_cnt", 32'(frame_cnt), exp_frames);
        chk("to_recover_sb_empty", sb.size(), 0);

        // Back-pressure: output must hold while stalled
        pkt_ready = 1'b0;
        push_payload({8'hA1, 8'hB3, 8'h00, 8'h00}, 2);
        exp_frames++;
        send_byte(8'h55); send_byte(8'h02); send_byte(8'hA1); send_byte(8'hB3); send_byte(8'h56);
        repeat (20) tick();
        chk("bp_valid", 32'(pkt_valid), 1);
        chk("bp_data", 32'({pkt_last, pkt_data}), 32'h0A1);
        pkt_ready = 1'b1;
        drain();
        chk("bp_sb_empty", sb.size(), 0);
        chk("bp_frame_cnt", 32'(frame_cnt), exp_frames);

        // Overrun: byte arrives while the frame is draining
        pkt_ready = 1'b0;
        push_payload({8'hA1, 8'hB3, 8'h00, 8'h00}, 2);
        exp_frames++;
        send_byte(8'h55); send_byte(8'h02); send_byte(8'hA1); send_byte(8'hB3); send_byte(8'h56);
        b_ovr = n_ovr; b_rxv = n_rxv;
        send_byte(8'h77);
        chk("ovr_pulse", n_ovr - b_ovr, 1);
        chk("ovr_acked", n_rxv - b_rxv, 1);
        pkt_ready = 1'b1;
        drain();
        chk("ovr_sb_empty", sb.size(), 0);
        chk("ovr_frame_cnt", 32'(frame_cnt), exp_frames);

        // Reset mid-payload, then a clean frame
        send_byte(8'h55); send_byte(8'h04); send_byte(8'h01); send_byte(8'h02);
        rst_n = 1'b0;
        #2;
        check_idle_outputs("midrst");
        exp_frames = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        stall_prev = 1'b0;
        tick();
        push_payload({8'hAB, 8'h00, 8'h00, 8'h00}, 1);
        exp_frames++;
        send_byte(8'h55); send_byte(8'h01); send_byte(8'hAB); send_byte(8'hAC);
        drain();
        chk("post_rst_frame_cnt", 32'(frame_cnt), exp_frames);
        chk("post_rst_sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
